// File: rtl/lcd_pkg.sv
// Shared constants, lock FSM encoding and geometry record for the RGB565 LCD receiver.
package lcd_pkg;

  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic [9:0]  h_active;
    logic [9:0]  v_active;
    logic [10:0] h_total;
    logic [9:0]  v_total;
  } geom_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Two register stages on DE/HSYNC/VSYNC with edge flags taken between stage 1 and stage 2.
// Sync inputs are normalised to active-high at stage 1; no backpressure, one sample per clock.
module lcd_sync_edge #(
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic de_i,
  input  logic hsync_i,
  input  logic vsync_i,
  output logic de_s1_o,
  output logic de_s2_o,
  output logic de_rise_o,
  output logic de_fall_o,
  output logic hs_edge_o,
  output logic vs_edge_o
);

  // bit 2 = vsync active, bit 1 = hsync active, bit 0 = DE
  logic [2:0] s1_q;
  logic [2:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {vsync_i == SYNC_ACT, hsync_i == SYNC_ACT, de_i};
      s2_q <= s1_q;
    end
  end

  assign de_s1_o   = s1_q[0];
  assign de_s2_o   = s2_q[0];
  assign de_rise_o = s1_q[0] & ~s2_q[0];
  assign de_fall_o = ~s1_q[0] & s2_q[0];
  assign hs_edge_o = s1_q[1] & ~s2_q[1];
  assign vs_edge_o = s1_q[2] & ~s2_q[2];

endmodule

// File: rtl/lcd_rgb_rx.sv
// RGB565 LCD bus monitor: recovers pixels with x/y, measures line/frame geometry, locks on format.
// Pixel outputs lag the bus by 2 PixelClk; purely passive tap, no backpressure.
module lcd_rgb_rx #(
  parameter int   H_ACTIVE    = lcd_pkg::H_ACTIVE_DEF,
  parameter int   V_ACTIVE    = lcd_pkg::V_ACTIVE_DEF,
  parameter int   LOCK_FRAMES = 2,
  parameter logic SYNC_ACT    = 1'b0
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        LCD_DE,
  input  logic        LCD_HSYNC,
  input  logic        LCD_VSYNC,
  input  logic [4:0]  LCD_R,
  input  logic [5:0]  LCD_G,
  input  logic [4:0]  LCD_B,
  output logic        pix_valid,
  output logic [15:0] pix_rgb,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic [9:0]  meas_h_active,
  output logic [10:0] meas_h_total,
  output logic [9:0]  meas_v_active,
  output logic [9:0]  meas_v_total,
  output logic        locked,
  output logic        fmt_err
);
  import lcd_pkg::*;

  localparam logic [9:0] H_EXP  = 10'(H_ACTIVE);
  localparam logic [9:0] V_EXP  = 10'(V_ACTIVE);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  logic de_s1, de_s2, de_rise, de_fall, hs_edge, vs_edge;

  lcd_sync_edge #(.SYNC_ACT(SYNC_ACT)) u_sync (
    .clk_i     (PixelClk),
    .rst_ni    (nRST),
    .de_i      (LCD_DE),
    .hsync_i   (LCD_HSYNC),
    .vsync_i   (LCD_VSYNC),
    .de_s1_o   (de_s1),
    .de_s2_o   (de_s2),
    .de_rise_o (de_rise),
    .de_fall_o (de_fall),
    .hs_edge_o (hs_edge),
    .vs_edge_o (vs_edge)
  );

  logic [RGB_W-1:0] rgb_s1_q, rgb_s2_q;
  logic [8:0]       x_q;
  logic [9:0]       h_cnt_q, v_cnt_q, hs_cnt_q;
  logic [10:0]      htot_cnt_q;
  logic [9:0]       meas_h_active_q, meas_v_active_q, meas_v_total_q;
  logic [10:0]      meas_h_total_q;

  lock_state_e state_q;
  logic [2:0]  match_cnt_q;
  geom_t       prev_q;
  logic        locked_q, fmt_err_q;

  geom_t       cur_geom;
  logic [9:0]  v_act_d, v_tot_d;
  logic        geom_ok, same_prev, line_bad;

  // A DE fall or HSYNC edge landing on the VSYNC edge belongs to the frame being closed.
  always_comb begin
    v_act_d           = de_fall ? sat_inc10(v_cnt_q) : v_cnt_q;
    v_tot_d           = hs_edge ? sat_inc10(hs_cnt_q) : hs_cnt_q;
    cur_geom.h_active = de_fall ? h_cnt_q : meas_h_active_q;
    cur_geom.h_total  = hs_edge ? sat_inc11(htot_cnt_q) : meas_h_total_q;
    cur_geom.v_active = v_act_d;
    cur_geom.v_total  = v_tot_d;
    geom_ok           = (cur_geom.h_active == H_EXP) && (cur_geom.v_active == V_EXP);
    same_prev         = (cur_geom == prev_q);
    line_bad          = de_fall && (h_cnt_q != H_EXP);
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      rgb_s1_q        <= '0;
      rgb_s2_q        <= '0;
      x_q             <= '0;
      h_cnt_q         <= '0;
      v_cnt_q         <= '0;
      hs_cnt_q        <= '0;
      htot_cnt_q      <= '0;
      meas_h_active_q <= '0;
      meas_h_total_q  <= '0;
      meas_v_active_q <= '0;
      meas_v_total_q  <= '0;
    end else begin
      rgb_s1_q <= {LCD_R, LCD_G, LCD_B};
      rgb_s2_q <= rgb_s1_q;

      // x and h_cnt move with stage 2 so they line up with the pixel on pix_rgb.
      if (de_rise) begin
        x_q     <= '0;
        h_cnt_q <= 10'd1;
      end else if (de_s1) begin
        x_q     <= (x_q == 9'h1FF) ? x_q : x_q + 9'd1;
        h_cnt_q <= sat_inc10(h_cnt_q);
      end

      if (de_fall) begin
        meas_h_active_q <= h_cnt_q;
      end

      if (hs_edge) begin
        meas_h_total_q <= sat_inc11(htot_cnt_q);
        htot_cnt_q     <= '0;
      end else begin
        htot_cnt_q     <= sat_inc11(htot_cnt_q);
      end

      if (vs_edge) begin
        meas_v_active_q <= v_act_d;
        meas_v_total_q  <= v_tot_d;
        v_cnt_q         <= '0;
        hs_cnt_q        <= '0;
      end else begin
        v_cnt_q         <= v_act_d;
        hs_cnt_q        <= v_tot_d;
      end
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= SEARCH;
      match_cnt_q <= '0;
      prev_q      <= '0;
      locked_q    <= 1'b0;
      fmt_err_q   <= 1'b0;
    end else begin
      fmt_err_q <= 1'b0;
      if (vs_edge) begin
        prev_q <= cur_geom;
      end
      case (state_q)
        SEARCH: begin
          if (vs_edge) begin
            state_q     <= MEASURE;
            match_cnt_q <= '0;
          end
        end
        MEASURE: begin
          // The first frame of a run has nothing to agree with yet, only the target size.
          if (vs_edge) begin
            if (geom_ok && ((match_cnt_q == 3'd0) || same_prev)) begin
              if (match_cnt_q == LOCK_N - 3'd1) begin
                state_q     <= LOCKED;
                locked_q    <= 1'b1;
                match_cnt_q <= '0;
              end else begin
                match_cnt_q <= match_cnt_q + 3'd1;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (line_bad || (vs_edge && !(geom_ok && same_prev))) begin
            fmt_err_q <= 1'b1;
            locked_q  <= 1'b0;
            state_q   <= SEARCH;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign pix_valid     = de_s2;
  assign pix_rgb       = rgb_s2_q;
  assign pix_x         = x_q;
  assign pix_y         = v_cnt_q[9] ? 9'h1FF : v_cnt_q[8:0];
  assign sof           = de_s2 && (x_q == 9'd0) && (v_cnt_q == 10'd0);
  assign eol           = de_fall;
  assign meas_h_active = meas_h_active_q;
  assign meas_h_total  = meas_h_total_q;
  assign meas_v_active = meas_v_active_q;
  assign meas_v_total  = meas_v_total_q;
  assign locked        = locked_q;
  assign fmt_err       = fmt_err_q;

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx on a shrunken 20x5 panel (h_total 28, v_total 8).
module tb_lcd_rgb_rx;

  localparam int HA = 20;
  localparam int VA = 5;
  localparam int HT = 28;
  localparam int VT = 8;
  localparam int HB = 4;
  localparam int VS_LINE = 6;

  logic        PixelClk = 1'b0;
  logic        nRST = 1'b0;
  logic        LCD_DE = 1'b0;
  logic        LCD_HSYNC = 1'b1;
  logic        LCD_VSYNC = 1'b1;
  logic [4:0]  LCD_R = '0;
  logic [5:0]  LCD_G = '0;
  logic [4:0]  LCD_B = '0;
  logic        pix_valid;
  logic [15:0] pix_rgb;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic        sof;
  logic        eol;
  logic [9:0]  meas_h_active;
  logic [10:0] meas_h_total;
  logic [9:0]  meas_v_active;
  logic [9:0]  meas_v_total;
  logic        locked;
  logic        fmt_err;

  lcd_rgb_rx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2), .SYNC_ACT(1'b0)) dut (
    .PixelClk      (PixelClk),
    .nRST          (nRST),
    .LCD_DE        (LCD_DE),
    .LCD_HSYNC     (LCD_HSYNC),
    .LCD_VSYNC     (LCD_VSYNC),
    .LCD_R         (LCD_R),
    .LCD_G         (LCD_G),
    .LCD_B         (LCD_B),
    .pix_valid     (pix_valid),
    .pix_rgb       (pix_rgb),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .sof           (sof),
    .eol           (eol),
    .meas_h_active (meas_h_active),
    .meas_h_total  (meas_h_total),
    .meas_v_active (meas_v_active),
    .meas_v_total  (meas_v_total),
    .locked        (locked),
    .fmt_err       (fmt_err)
  );

  always #5 PixelClk = ~PixelClk;

  int tests = 0;
  int fails = 0;
  int sof_n = 0;
  int eol_n = 0;
  int fmt_n = 0;
  int cd = 0;
  string probe_tag;
  logic [15:0] exp_rgb;
  int exp_x, exp_y;
  logic exp_sof, exp_eol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] colour(input int l, input int a);
    if (l == 3 && a == 17) return 16'hF80A;
    return {5'(a + 1), 6'(l + 2), 5'(a ^ 5)};
  endfunction

  task automatic observe();
    sof_n += int'(sof);
    eol_n += int'(eol);
    fmt_n += int'(fmt_err);
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        chk({probe_tag, "_valid"}, 32'(pix_valid), 1);
        chk({probe_tag, "_rgb"},   32'(pix_rgb), 32'(exp_rgb));
        chk({probe_tag, "_x"},     32'(pix_x), exp_x);
        chk({probe_tag, "_y"},     32'(pix_y), exp_y);
        chk({probe_tag, "_sof"},   32'(sof), 32'(exp_sof));
        chk({probe_tag, "_eol"},   32'(eol), 32'(exp_eol));
      end
    end
  endtask

  task automatic tick();
    @(negedge PixelClk);
    observe();
  endtask

  // One frame: lines 0..VA-1 active, VSYNC low on VS_LINE, HSYNC low on columns 0..1.
  task automatic gen_frame(input int short_line, input int rst_line, input logic early_vs,
                           input logic probe);
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < HT; c++) begin
        int a;
        logic de;
        logic [15:0] px;
        tick();
        if (l == rst_line && c == 10) begin
          nRST = 1'b0;
          #1;
          chk("rst_mid_valid",  32'(pix_valid), 0);
          chk("rst_mid_x",      32'(pix_x), 0);
          chk("rst_mid_rgb",    32'(pix_rgb), 0);
          chk("rst_mid_hact",   32'(meas_h_active), 0);
          chk("rst_mid_htot",   32'(meas_h_total), 0);
          chk("rst_mid_locked", 32'(locked), 0);
        end
        if (l == rst_line && c == 13) nRST = 1'b1;
        a  = c - HB;
        de = (l < VA) && (a >= 0) && (a < ((l == short_line) ? HA - 1 : HA));
        px = de ? colour(l, a) : 16'h0000;
        LCD_DE    = de;
        LCD_HSYNC = !(c < 2);
        LCD_VSYNC = !((l == VS_LINE) ||
                      (early_vs && ((l == VA - 1 && a >= HA) || (l >= VA && l <= VS_LINE))));
        {LCD_R, LCD_G, LCD_B} = px;
        if (probe && de && ((l == 3 && a == 17) || (l == 0 && a == 0) || (l == 1 && a == HA - 1))) begin
          probe_tag = (l == 3) ? "pix17_3" : (l == 0) ? "sof_pix" : "eol_pix";
          exp_rgb   = (l == 3) ? 16'hF80A : px;
          exp_x     = a;
          exp_y     = l;
          exp_sof   = (l == 0 && a == 0);
          exp_eol   = (l == 1);
          cd        = 2;
        end
      end
    end
  endtask

  initial begin
    // Busy bus during reset must not leak into the pipeline.
    LCD_DE = 1'b1; LCD_HSYNC = 1'b0; LCD_VSYNC = 1'b0;
    LCD_R = 5'h1F; LCD_G = 6'h3F; LCD_B = 5'h1F;
    repeat (3) @(negedge PixelClk);
    chk("rst_valid",  32'(pix_valid), 0);
    chk("rst_rgb",    32'(pix_rgb), 0);
    chk("rst_x",      32'(pix_x), 0);
    chk("rst_y",      32'(pix_y), 0);
    chk("rst_sof",    32'(sof), 0);
    chk("rst_eol",    32'(eol), 0);
    chk("rst_hact",   32'(meas_h_active), 0);
    chk("rst_htot",   32'(meas_h_total), 0);
    chk("rst_vact",   32'(meas_v_active), 0);
    chk("rst_vtot",   32'(meas_v_total), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_fmt",    32'(fmt_err), 0);
    LCD_DE = 1'b0; LCD_HSYNC = 1'b1; LCD_VSYNC = 1'b1;
    {LCD_R, LCD_G, LCD_B} = 16'h0000;
    @(negedge PixelClk);
    nRST = 1'b1;

    // DE stuck high for 600 cycles.
    for (int i = 0; i < 600; i++) begin
      tick();
      LCD_DE = 1'b1;
      {LCD_R, LCD_G, LCD_B} = 16'h1234;
    end
    chk("stuck_x_sat", 32'(pix_x), 511);
    repeat (5) begin
      tick();
      LCD_DE = 1'b0;
    end
    chk("stuck_hact",   32'(meas_h_active), 600);
    chk("stuck_valid",  32'(pix_valid), 0);
    chk("stuck_locked", 32'(locked), 0);

    // Clean frames: SEARCH -> MEASURE on frame 0, lock after frames 1 and 2 match.
    fmt_n = 0;
    gen_frame(-1, -1, 1'b0, 1'b0);
    chk("f0_locked", 32'(locked), 0);
    gen_frame(-1, -1, 1'b0, 1'b0);
    chk("f1_locked", 32'(locked), 0);
    gen_frame(-1, -1, 1'b0, 1'b0);
    chk("f2_locked", 32'(locked), 1);
    chk("f2_hact",   32'(meas_h_active), HA);
    chk("f2_htot",   32'(meas_h_total), HT);
    chk("f2_vact",   32'(meas_v_active), VA);
    chk("f2_vtot",   32'(meas_v_total), VT);

    sof_n = 0; eol_n = 0;
    gen_frame(-1, -1, 1'b0, 1'b1);
    chk("f3_sof_count", 32'(sof_n), 1);
    chk("f3_eol_count", 32'(eol_n), VA);
    chk("f3_fmt_count", 32'(fmt_n), 0);
    chk("f3_locked",    32'(locked), 1);

    // One line one pixel short while locked.
    fmt_n = 0;
    gen_frame(2, -1, 1'b0, 1'b0);
    chk("short_fmt_count", 32'(fmt_n), 1);
    chk("short_locked",    32'(locked), 0);
    gen_frame(-1, -1, 1'b0, 1'b0);
    chk("relock_f1_locked", 32'(locked), 0);
    gen_frame(-1, -1, 1'b0, 1'b0);
    chk("relock_f2_locked", 32'(locked), 1);
    chk("relock_fmt_count", 32'(fmt_n), 1);

    // Reset pulse mid-line, then SEARCH -> MEASURE -> two matching frames.
    gen_frame(-1, 2, 1'b0, 1'b0);
    chk("postrst_f0_locked", 32'(locked), 0);
    gen_frame(-1, -1, 1'b0, 1'b0);
    chk("postrst_f1_locked", 32'(locked), 0);
    gen_frame(-1, -1, 1'b0, 1'b0);
    chk("postrst_f2_locked", 32'(locked), 1);

    // VSYNC goes active on the same cycle DE falls on the last active line.
    gen_frame(-1, -1, 1'b1, 1'b0);
    chk("coinc_vact", 32'(meas_v_active), VA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
